// File: rtl/cpu_out_uart_tx.sv
// cpu_out_uart_tx: queues bytes from CPU OUT strobes and sends them as UART frames.
// Default build sends 8N1 frames. Define CPU_OUT_TX_PARITY_EN to insert an
// even-parity bit before the stop bit (8E1).
module cpu_out_uart_tx #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             out_valid_i,
    input  logic [7:0]       out_data_i,
    output logic             out_ready_o,
    input  logic             clr_overflow_i,
    output logic             tx_o,
    output logic             tx_oeb_o,
    output logic             busy_o,
    output logic [FIFO_AW:0] fifo_level_o,
    output logic             overflow_o
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

`ifdef CPU_OUT_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ready_q, overflow_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
`ifdef CPU_OUT_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic       push, drop, pop, bit_end, have_data;
    logic [7:0] rd_data;

    assign push      = out_valid_i & ready_q;
    assign drop      = out_valid_i & ~ready_q;
    assign bit_end   = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign have_data = (level_q != '0);
    assign rd_data   = mem[rd_ptr_q];

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr_q] <= out_data_i;
    end

    // FIFO pointers, level, ready flag and sticky overflow
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            level_q <= level_d;
            ready_q <= (level_d != LVL_W'(DEPTH));
            if (drop)                overflow_q <= 1'b1;
            else if (clr_overflow_i) overflow_q <= 1'b0;
        end
    end

    // Transmit FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Transmit FSM next state; STOP chains straight into START when data is queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (have_data) state_d = START;
            START: if (bit_end) state_d = DATA;
`ifdef CPU_OUT_TX_PARITY_EN
            DATA:   if (bit_end && idx_q == 3'd7) state_d = PARITY;
            PARITY: if (bit_end) state_d = STOP;
`else
            DATA:  if (bit_end && idx_q == 3'd7) state_d = STOP;
`endif
            STOP:  if (bit_end) state_d = have_data ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        pop     = 1'b0;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        busy_d  = (state_d != IDLE);
        tx_d    = 1'b1;
`ifdef CPU_OUT_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q == IDLE || bit_end) cnt_d = '0;
        else                            cnt_d = cnt_q + CNT_W'(1);

        if (have_data && (state_q == IDLE || (state_q == STOP && bit_end))) begin
            pop     = 1'b1;
            shift_d = rd_data;
            idx_d   = 3'd0;
`ifdef CPU_OUT_TX_PARITY_EN
            parity_d = ^rd_data;
`endif
        end

        if (state_q == DATA && bit_end) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
        end

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef CPU_OUT_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef CPU_OUT_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef CPU_OUT_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_o         = tx_q;
    assign tx_oeb_o     = 1'b0;
    assign busy_o       = busy_q;
    assign fifo_level_o = level_q;
    assign out_ready_o  = ready_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Bench for cpu_out_uart_tx (CLK_DIV=4, FIFO_AW=2); follows CPU_OUT_TX_PARITY_EN.
module tb_cpu_out_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FIFO_AW = 2;
`ifdef CPU_OUT_TX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic             clk;
    logic             rst_n;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             clr_overflow;
    logic             tx;
    logic             tx_oeb;
    logic             busy;
    logic [FIFO_AW:0] fifo_level;
    logic             overflow;

    int tests_run = 0;
    int failures  = 0;

    // Scoreboard entries: {framing_error, parity_bit, data}
    logic [9:0] exp_q[$];
    logic [9:0] rx_q[$];
    int         rx_rd = 0;

    cpu_out_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .wb_clk_i       (clk),
        .wb_rst_n       (rst_n),
        .out_valid_i    (out_valid),
        .out_data_i     (out_data),
        .out_ready_o    (out_ready),
        .clr_overflow_i (clr_overflow),
        .tx_o           (tx),
        .tx_oeb_o       (tx_oeb),
        .busy_o         (busy),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line receiver: decodes frames mid-bit and queues them; reset aborts a frame
    int         mon_cnt;
    int         mon_k;
    bit         mon_active;
    logic       mon_prev;
    logic       mon_err;
    logic       mon_par;
    logic [7:0] mon_byte;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
            mon_cnt    = 0;
        end else if (!mon_active) begin
            if (mon_prev === 1'b1 && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_err    = 1'b0;
                mon_par    = 1'b0;
                mon_byte   = 8'h00;
            end
            mon_prev = tx;
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt % CLK_DIV == CLK_DIV / 2) begin
                mon_k = mon_cnt / CLK_DIV;
                if (mon_k == 0) begin
                    if (tx !== 1'b0) mon_err = 1'b1;
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = tx;
                end else if (PAR_EN && mon_k == 9) begin
                    mon_par = tx;
                end else begin
                    if (tx !== 1'b1) mon_err = 1'b1;
                    rx_q.push_back({mon_err, mon_par, mon_byte});
                    mon_active = 1'b0;
                    mon_prev   = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] exp_entry(input logic [7:0] b);
        return {1'b0, (PAR_EN ? ^b : 1'b0), b};
    endfunction

    // Expected line level for each cycle of a frame, bit i = cycle i
    function automatic logic [63:0] exp_wave(input logic [7:0] b);
        logic [63:0] w;
        int k;
        w = '0;
        for (int i = 0; i < FRAME; i++) begin
            k = i / CLK_DIV;
            if (k == 0)                 w[i] = 1'b0;
            else if (k <= 8)            w[i] = b[k-1];
            else if (PAR_EN && k == 9)  w[i] = ^b;
            else                        w[i] = 1'b1;
        end
        return w;
    endfunction

    // Drive inputs for the next edge, then return at the following negedge
    task automatic step(input logic v, input logic [7:0] d, input logic clr);
        @(posedge clk);
        #1;
        out_valid    = v;
        out_data     = d;
        clr_overflow = clr;
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 * FRAME; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (busy === 1'b0 && fifo_level === '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain_scoreboard(input string name);
        logic [9:0] e;
        logic [9:0] r;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (rx_rd >= rx_q.size()) begin
                failures++;
                $display("FAIL %s frame: got none, expected %h", name, e);
            end else begin
                r = rx_q[rx_rd];
                rx_rd++;
                if (r !== e) begin
                    failures++;
                    $display("FAIL %s frame: got %h, expected %h", name, r, e);
                end
            end
        end
        tests_run++;
        if (rx_rd != rx_q.size()) begin
            failures++;
            $display("FAIL %s extra_frames: got %0d, expected 0", name, rx_q.size() - rx_rd);
        end
        rx_rd = rx_q.size();
    endtask

    task automatic test_reset();
        out_valid    = 1'b0;
        out_data     = 8'h00;
        clr_overflow = 1'b0;
        rst_n        = 1'b0;
        #12;
        tests_run++; if (tx !== 1'b1)         begin failures++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        tests_run++; if (tx_oeb !== 1'b0)     begin failures++; $display("FAIL reset_oeb: got %b, expected 0", tx_oeb); end
        tests_run++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests_run++; if (fifo_level !== '0)   begin failures++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
        tests_run++; if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        tests_run++; if (out_ready !== 1'b1)  begin failures++; $display("FAIL reset_ready: got %b, expected 1", out_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame(input logic [7:0] b, input string name);
        logic [63:0] w;
        logic [63:0] ew;
        int busy_n;
        ew = exp_wave(b);
        w = '0;
        busy_n = 0;
        for (int c = 0; c < FRAME + 6; c++) begin
            step(c == 0, b, 1'b0);
            if (c == 0) exp_q.push_back(exp_entry(b));
            if (busy === 1'b1) busy_n++;
            if (c == 1) begin
                tests_run++;
                if (tx !== 1'b1 || fifo_level !== 3'd1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s latency: got tx=%b level=%0d busy=%b, expected tx=1 level=1 busy=0",
                             name, tx, fifo_level, busy);
                end
            end
            if (c >= 2 && c < 2 + FRAME) w[c-2] = tx;
        end
        tests_run++;
        if (w !== ew) begin failures++; $display("FAIL %s wave: got %h, expected %h", name, w, ew); end
        tests_run++;
        if (busy_n != FRAME) begin failures++; $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_n, FRAME); end
        tests_run++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL %s overflow: got %b, expected 0", name, overflow); end
        drain_scoreboard(name);
    endtask

    task automatic test_back_to_back();
        int run, max_run, total, peak;
        logic [1:0] seam;
        run = 0; max_run = 0; total = 0; peak = 0; seam = 2'b00;
        for (int c = 0; c < 3 * FRAME + 8; c++) begin
            step(c < 3, 8'(c + 1), 1'b0);
            if (c < 3) exp_q.push_back(exp_entry(8'(c + 1)));
            if (busy === 1'b1) begin
                run++;
                total++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            if (c == FRAME + 1) seam[1] = tx;
            if (c == FRAME + 2) seam[0] = tx;
        end
        tests_run++;
        if (max_run != 3 * FRAME) begin failures++; $display("FAIL b2b busy_run: got %0d, expected %0d", max_run, 3 * FRAME); end
        tests_run++;
        if (total != 3 * FRAME) begin failures++; $display("FAIL b2b busy_total: got %0d, expected %0d", total, 3 * FRAME); end
        tests_run++;
        if (peak != 2) begin failures++; $display("FAIL b2b level_peak: got %0d, expected 2", peak); end
        tests_run++;
        if (seam !== 2'b10) begin failures++; $display("FAIL b2b stop_start_seam: got %b, expected 10", seam); end
        drain_scoreboard("b2b");
    endtask

    task automatic test_overflow();
        bit ok;
        for (int c = 0; c < 10; c++) begin
            if (c < 6)       step(1'b1, 8'(8'h10 + c), 1'b0);
            else if (c == 6) step(1'b1, 8'h16, 1'b1);
            else             step(1'b0, 8'h00, 1'b0);
            if (c < 5) exp_q.push_back(exp_entry(8'(8'h10 + c)));
            if (c == 5) begin
                tests_run++;
                if (fifo_level !== 3'd4 || out_ready !== 1'b0 || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_full: got level=%0d ready=%b ovf=%b, expected level=4 ready=0 ovf=0",
                             fifo_level, out_ready, overflow);
                end
            end
            if (c == 6) begin
                tests_run++;
                if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop: got %b, expected 1", overflow); end
            end
            if (c == 7) begin
                tests_run++;
                if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
                    failures++;
                    $display("FAIL ovf_set_wins: got ovf=%b level=%0d, expected ovf=1 level=4", overflow, fifo_level);
                end
            end
        end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin failures++; $display("FAIL ovf_idle_timeout: got busy=%b, expected 0", busy); end
        tests_run++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        tests_run++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
        drain_scoreboard("ovf");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bytes [3];
        int busy_n;
        bit ok;
        bytes[0] = 8'h55; bytes[1] = 8'h66; bytes[2] = 8'h77;
        for (int c = 0; c < 20; c++) begin
            step(c < 3, (c < 3) ? bytes[c] : 8'h00, 1'b0);
        end
        tests_run++;
        if (fifo_level !== 3'd2 || busy !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: got level=%0d busy=%b tx=%b, expected level=2 busy=1 tx=0",
                     fifo_level, busy, tx);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== '0 || out_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async: got tx=%b busy=%b level=%0d ready=%b, expected 1 0 0 1",
                     tx, busy, fifo_level, out_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busy_n = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            step(1'b0, 8'h00, 1'b0);
            if (busy !== 1'b0 || tx !== 1'b1) busy_n++;
        end
        tests_run++;
        if (busy_n != 0) begin failures++; $display("FAIL rstmid_quiet: got %0d active cycles, expected 0", busy_n); end
        drain_scoreboard("rstmid_abort");
        step(1'b1, 8'h3C, 1'b0);
        exp_q.push_back(exp_entry(8'h3C));
        wait_idle(ok);
        tests_run++;
        if (!ok) begin failures++; $display("FAIL rstmid_idle_timeout: got busy=%b, expected 0", busy); end
        drain_scoreboard("rstmid_after");
    endtask

    task automatic test_push_pop_level2();
        logic [7:0] bytes [4];
        bit ok;
        bytes[0] = 8'h81; bytes[1] = 8'h42; bytes[2] = 8'h24; bytes[3] = 8'h18;
        for (int c = 0; c < FRAME + 3; c++) begin
            if (c < 3)              step(1'b1, bytes[c], 1'b0);
            else if (c == FRAME + 1) step(1'b1, bytes[3], 1'b0);
            else                    step(1'b0, 8'h00, 1'b0);
            if (c < 3) exp_q.push_back(exp_entry(bytes[c]));
            if (c == FRAME + 1) begin
                exp_q.push_back(exp_entry(bytes[3]));
                tests_run++;
                if (fifo_level !== 3'd2 || tx !== 1'b1) begin
                    failures++;
                    $display("FAIL pp_before: got level=%0d tx=%b, expected level=2 tx=1", fifo_level, tx);
                end
            end
            if (c == FRAME + 2) begin
                tests_run++;
                if (fifo_level !== 3'd2 || tx !== 1'b0) begin
                    failures++;
                    $display("FAIL pp_after: got level=%0d tx=%b, expected level=2 tx=0", fifo_level, tx);
                end
            end
        end
        wait_idle(ok);
        tests_run++;
        if (!ok) begin failures++; $display("FAIL pp_idle_timeout: got busy=%b, expected 0", busy); end
        drain_scoreboard("pp_order");
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, "frame_a5");
        test_frame(8'h07, "frame_07");
        test_frame(8'h03, "frame_03");
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_push_pop_level2();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/cpu_out_uart_tx.md
Name: cpu_out_uart_tx

Overview:
- Transmit side of the CPU's I/O path. The RAM-load path brings bytes into the core; this block takes bytes the CPU writes with its OUT instruction and sends them serially on one user GPIO pad as 8N1 UART frames.
- Sits between the CPU's out_reg update strobe and io_out/io_oeb.
- A small FIFO decouples the OUT rate from the line rate. Overflow is flagged sticky.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit; legal range 2..65535.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4 entries).

Ports:
- wb_clk_i  input  1  single block clock
- wb_rst_n  input  1  asynchronous active-low reset
- out_valid_i  input  1  one-cycle strobe: CPU executed OUT
- out_data_i  input  8  byte to transmit (the out_reg value)
- out_ready_o  output  1  FIFO not full
- clr_overflow_i  input  1  synchronous clear of overflow_o
- tx_o  output  1  serial line, idle high
- tx_oeb_o  output  1  pad output-enable, active low
- busy_o  output  1  frame in progress
- fifo_level_o  output  FIFO_AW+1  entries currently queued
- overflow_o  output  1  sticky: a strobe was dropped

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_n is asynchronous, active-low. All state uses that clock and reset.
- Reset values (immediate on wb_rst_n low): tx_o=1, tx_oeb_o=0 (constant 0 thereafter), busy_o=0, fifo_level_o=0, overflow_o=0, out_ready_o=1, FSM=IDLE, FIFO pointers=0.
- FIFO push:
  - out_valid_i && out_ready_o -> out_data_i written at that edge.
  - out_valid_i && !out_ready_o -> byte dropped, overflow_o set at that edge.
  - out_ready_o derives from the registered level. A push while full is dropped even if a pop occurs in the same cycle.
- FIFO pop:
  - Only the FSM pops: IDLE or end of STOP with level>0.
  - Simultaneous push and pop -> level unchanged.
  - Pointers wrap modulo depth.
- overflow_o: clr_overflow_i clears it. If clear and a new drop happen in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLK_DIV-1; an index counts 0..7.
  - IDLE: tx_o=1. If level>0: pop into shift register, enter START. tx_o=0 from that edge.
  - Latency: push into an empty FIFO at edge N with FSM in IDLE -> tx_o low from edge N+1.
  - START: hold 0 for CLK_DIV cycles, then DATA.
  - DATA: send shift[0] LSB-first, CLK_DIV cycles per bit. After bit 7 -> STOP.
  - STOP: tx_o=1 for CLK_DIV cycles. At its last cycle, if level>0, pop and go directly to START with no idle gap; else IDLE.
- busy_o: 1 in START/DATA/STOP, 0 in IDLE.
- Frame length: 10*CLK_DIV cycles.
- Reset mid-frame aborts the frame. The line returns high immediately and the FIFO contents are discarded.

Optional Feature:
- Macro: CPU_OUT_TX_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles. Frame = 11*CLK_DIV cycles (8E1).
- Undefined: no PARITY state, no parity logic. Frame = 10*CLK_DIV cycles (8N1).

Test Plan:
- CLK_DIV=4, push 0xA5 when idle -> tx_o low 1 cycle after the push edge, for 4 cycles. Then bits 1,0,1,0,0,1,0,1, 4 cycles each. Then stop high 4 cycles. busy_o high exactly 40 cycles. overflow_o=0.
- CLK_DIV=4, push 0x01,0x02,0x03 on consecutive cycles -> three frames back-to-back, 120 contiguous busy cycles, no high gap between the stop bit and the next start bit. fifo_level_o peaks at 2.
- FIFO_AW=2, push 0x10..0x15 on 6 consecutive cycles:
  - 0x10 is popped at the next edge.
  - 0x11..0x14 fill the FIFO (level=4, out_ready_o=0).
  - 0x15 is dropped and overflow_o=1.
  - Exactly 5 frames are sent.
  - clr_overflow_i pulse -> overflow_o=0.
- Assert wb_rst_n=0 mid-DATA (bit 3) with 2 bytes queued -> tx_o=1, busy_o=0, fifo_level_o=0 asynchronously. After release, no frame is sent until a new push.
- CPU_OUT_TX_PARITY_EN defined, CLK_DIV=4, push 0x07 -> parity bit=1 for 4 cycles after data bit 7, then stop. busy_o high 44 cycles. Push 0x03 -> parity bit=0.
- Push and pop in the same cycle at level=2 (end of a STOP bit) -> level stays 2. Byte order is preserved on the line.
